mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//  Bus-side responder for the CPU memory port (address, wr, write data, read data). Sits beside Memoria.
//  Claims the 256-byte window at BASE_ADDR; the top level steers read data to the CPU with sel.
//  Provides a free-running timer with compare interrupt and a transmit FIFO drained by a valid/ready port.
//  Timing matches Memoria: 1-cycle registered read; write commits at the posedge where wr=1.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_FF00  window base; window = BASE_ADDR..BASE_ADDR+8'hFF, word offsets only
//  FIFO_DEPTH  4              TX FIFO entries; power of 2, >=2
// PORTS
//  clk       in   1   system clock, all state on posedge
//  reset     in   1   asynchronous, active-high; clears all state
//  address   in   32  byte address from the IorD mux
//  wr        in   1   write strobe (1 = write this cycle)
//  data_in   in   32  write data from Store unit
//  data_out  out  32  registered read data
//  sel       out  1   registered: address was inside window on previous posedge
//  irq       out  1   STATUS.match & CTRL.irq_en (combinational from regs)
//  tx_data   out  32  FIFO head word
//  tx_valid  out  1   FIFO not empty
//  tx_ready  in   1   consumer accepts head when tx_valid & tx_ready at posedge
// BEHAVIOUR
//  Hit = address[31:8]==BASE_ADDR[31:8]. Offset = address[7:2]; address[1:0] ignored.
//  Register map (offset in bytes):
//   0x00 COUNT  RW 32b; +1 every cycle when CTRL.run; wraps FFFF_FFFF->0
//   0x04 CMP    RW 32b
//   0x08 CTRL   RW bit0 run, bit1 irq_en; other bits read 0
//   0x0C STATUS R/W1C: bit0 match (sticky), bit3 tx_ovf (sticky); RO: bit1 fifo_full, bit2 fifo_empty
//   0x10 TXDATA W: push data_in; reads 0
//   0x14 LEVEL  RO: FIFO occupancy (0..FIFO_DEPTH)
//   other offsets: reads 0, writes ignored.
//  Read: at each posedge data_out <= hit ? reg[offset] (pre-update value) : 0; sel <= hit.
//   Read issued with wr=1 still returns the pre-write value.
//  Write (hit & wr): COUNT write beats increment same cycle. STATUS write-1 clears bit0/bit3;
//   a match set in the same cycle as its clear wins (bit stays 1).
//  Match: when CTRL.run and COUNT==CMP (pre-increment value), set STATUS.match next posedge.
//  FIFO: push = hit & wr & offset 0x10; pop = tx_valid & tx_ready.
//   full & push & !pop -> word dropped, STATUS.tx_ovf <= 1, level unchanged.
//   full & push & pop -> both happen, level stays FIFO_DEPTH, no overflow.
//   empty & push -> tx_valid=1 next cycle, tx_data = pushed word (no bypass same cycle).
//   Read/write pointers wrap modulo FIFO_DEPTH; level counter is clog2(FIFO_DEPTH)+1 bits.
//  tx_data stable while tx_valid & !tx_ready.
//  Reset (any time, incl. mid-transfer): COUNT=CMP=CTRL=STATUS=0, FIFO empty, data_out=0,
//   sel=0, irq=0, tx_valid=0, tx_data=0 (pointer/level clear; stale entries unreachable).
// TESTING
//  1 Write CMP=5, COUNT=0, CTRL=3 -> STATUS.match and irq rise on the posedge after COUNT reads 5;
//    write STATUS=1 -> irq falls next cycle.
//  2 Push 0xA,0xB,0xC,0xD,0xE with tx_ready=0 -> LEVEL=4, fifo_full=1, tx_ovf=1, tx_data=0xA;
//    then tx_ready=1 -> pops A,B,C,D in order, tx_valid drops after D.
//  3 With FIFO full and tx_ready=1, push 0x55 -> LEVEL stays 4, tx_ovf stays 0, 0x55 popped last.
//  4 Write COUNT=FFFF_FFFF, run=1 -> next read of COUNT returns 0 or small count (wrap), no match
//    unless CMP equals the passed value.
//  5 Read 0x0C while address BASE_ADDR+0x40 and address 0x0000_0100 -> data_out 0 and 0 respectively;
//    sel=1 then 0.
//  6 Assert reset asynchronously mid-burst with tx_valid=1 -> all outputs 0 before next clock edge.

Source files
------------

// File: rtl/mmio_responder_if.sv
// -----------------------------------------------------------------------------
// mmio_responder_if
//   Bundles the CPU memory-port signals and the TX stream port of the MMIO
//   responder so that the responder and its user connect through one port.
//
//   address   32  byte address from the IorD mux        (master -> slave)
//   wr         1  write strobe                           (master -> slave)
//   data_in   32  write data                             (master -> slave)
//   data_out  32  registered read data                   (slave  -> master)
//   sel        1  registered window hit                  (slave  -> master)
//   irq        1  timer compare interrupt                (slave  -> master)
//   tx_data   32  TX FIFO head word                      (slave  -> master)
//   tx_valid   1  TX FIFO not empty                      (slave  -> master)
//   tx_ready   1  consumer accepts head word             (master -> slave)
// -----------------------------------------------------------------------------
interface mmio_responder_if;
    logic [31:0] address;
    logic        wr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        sel;
    logic        irq;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  address, wr, data_in, tx_ready,
        output data_out, sel, irq, tx_data, tx_valid
    );

    modport master (
        output address, wr, data_in, tx_ready,
        input  data_out, sel, irq, tx_data, tx_valid
    );
endinterface

// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//   Bus-side responder living next to the main memory on the CPU memory port.
//   Claims a 256-byte window at BASE_ADDR and provides:
//     - a free-running 32-bit timer (COUNT) with compare register (CMP) and a
//       sticky match flag that can raise irq,
//     - a transmit FIFO filled by writes to TXDATA and drained over a
//       valid/ready stream.
//   Timing mirrors the memory: read data is registered (one cycle latency,
//   returns the value before any same-cycle update) and writes commit at the
//   posedge where wr is high.
//
// Ports
//   clk     system clock, all state on posedge
//   reset   asynchronous, active-high; clears all state
//   bus     mmio_responder_if.slave (address/wr/data_in in, data_out/sel/irq
//           out, tx_data/tx_valid out, tx_ready in)
//
// Register map (byte offset)
//   0x00 COUNT  RW   0x04 CMP    RW   0x08 CTRL   RW {irq_en, run}
//   0x0C STATUS {tx_ovf W1C, fifo_empty, fifo_full, match W1C}
//   0x10 TXDATA W push, reads 0      0x14 LEVEL  RO FIFO occupancy
// -----------------------------------------------------------------------------
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    mmio_responder_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [5:0] OFF_COUNT  = 6'h00;
    localparam logic [5:0] OFF_CMP    = 6'h01;
    localparam logic [5:0] OFF_CTRL   = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;
    localparam logic [5:0] OFF_TXDATA = 6'h04;
    localparam logic [5:0] OFF_LEVEL  = 6'h05;

    // ---------------------------------------------------------------- decode
    logic       hit;
    logic [5:0] offset;
    logic       wr_hit;

    assign hit    = (bus.address[31:8] == BASE_ADDR[31:8]);
    assign offset = bus.address[7:2];
    assign wr_hit = hit & bus.wr;

    // Byte-lane bits are deliberately ignored: accesses are word-only.
    logic unused_byte_lane;
    assign unused_byte_lane = &{1'b0, bus.address[1:0]};

    // ---------------------------------------------------------------- state
    logic [31:0]      count_q,    count_d;
    logic [31:0]      cmp_q,      cmp_d;
    logic             run_q,      run_d;
    logic             irq_en_q,   irq_en_d;
    logic             match_q,    match_d;
    logic             ovf_q,      ovf_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [LVL_W-1:0] level_q,    level_d;
    logic [31:0]      data_out_q, data_out_d;
    logic             sel_q,      sel_d;

    // FIFO storage has no reset: pointers and level clear, so stale entries
    // can never be presented.
    logic [31:0] fifo_mem [FIFO_DEPTH];

    // ---------------------------------------------------------------- FIFO control
    logic fifo_full;
    logic fifo_empty;
    logic push_req;
    logic push;
    logic pop;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign push_req   = wr_hit & (offset == OFF_TXDATA);
    assign pop        = ~fifo_empty & bus.tx_ready;
    // A push into a full FIFO is still accepted when a pop frees a slot on
    // the same edge.
    assign push       = push_req & (~fifo_full | pop);

    // ---------------------------------------------------------------- next state
    logic match_set;
    logic ovf_set;
    logic status_wr;

    assign match_set = run_q & (count_q == cmp_q);
    assign ovf_set   = push_req & fifo_full & ~pop;
    assign status_wr = wr_hit & (offset == OFF_STATUS);

    always_comb begin
        count_d  = count_q;
        cmp_d    = cmp_q;
        run_d    = run_q;
        irq_en_d = irq_en_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;

        // A software write to COUNT takes precedence over the increment.
        if (wr_hit && offset == OFF_COUNT) begin
            count_d = bus.data_in;
        end else if (run_q) begin
            count_d = count_q + 32'd1;
        end

        if (wr_hit && offset == OFF_CMP) begin
            cmp_d = bus.data_in;
        end

        if (wr_hit && offset == OFF_CTRL) begin
            run_d    = bus.data_in[0];
            irq_en_d = bus.data_in[1];
        end

        // Setting has priority over a simultaneous write-1-to-clear.
        match_d = match_set | (match_q & ~(status_wr & bus.data_in[0]));
        ovf_d   = ovf_set   | (ovf_q   & ~(status_wr & bus.data_in[3]));

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        data_out_d = 32'd0;
        sel_d      = hit;
        if (hit) begin
            case (offset)
                OFF_COUNT:  data_out_d = count_q;
                OFF_CMP:    data_out_d = cmp_q;
                OFF_CTRL:   data_out_d = {30'd0, irq_en_q, run_q};
                OFF_STATUS: data_out_d = {28'd0, ovf_q, fifo_empty, fifo_full, match_q};
                OFF_LEVEL:  data_out_d = {{(32 - LVL_W){1'b0}}, level_q};
                default:    data_out_d = 32'd0;
            endcase
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            cmp_q      <= '0;
            run_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            data_out_q <= '0;
            sel_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            run_q      <= run_d;
            irq_en_q   <= irq_en_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            data_out_q <= data_out_d;
            sel_q      <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.data_in;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.data_out = data_out_q;
    assign bus.sel      = sel_q;
    assign bus.irq      = match_q & irq_en_q;
    assign bus.tx_valid = ~fifo_empty;
    // Forced to zero when empty so reset visibly clears tx_data.
    assign bus.tx_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_responder
//   Directed stimulus with hand-computed expectations. Reads and TX pops are
//   checked by a scoreboard: the stimulus queues expected values, and a
//   monitor on the falling edge pops and compares them whenever the DUT
//   presents read data (one cycle after a read) or a TX handshake.
// -----------------------------------------------------------------------------
module tb_mmio_responder;
    localparam logic [31:0] B = 32'hFFFF_FF00;

    logic clk;
    logic reset;
    mmio_responder_if bus();

    mmio_responder #(
        .BASE_ADDR  (B),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [32:0] rd_q [$];   // {sel, data_out}
    string       rd_name_q [$];
    logic [31:0] tx_q [$];
    logic        rd_issue   = 1'b0;
    logic        rd_pending = 1'b0;

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        logic [32:0] exp_rd;
        string       nm;
        logic [31:0] exp_tx;
        if (rd_pending) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected: got sel=%0b data=%h, no expectation queued",
                         bus.sel, bus.data_out);
            end else begin
                exp_rd = rd_q.pop_front();
                nm     = rd_name_q.pop_front();
                if ({bus.sel, bus.data_out} !== exp_rd) begin
                    bad++;
                    $display("FAIL %s: got sel=%0b data=%h, want sel=%0b data=%h",
                             nm, bus.sel, bus.data_out, exp_rd[32], exp_rd[31:0]);
                end else begin
                    $display("read %s: sel=%0b data=%h", nm, bus.sel, bus.data_out);
                end
            end
        end
        rd_pending = rd_issue;
        if (!reset && bus.tx_valid && bus.tx_ready) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got tx_data=%h, nothing expected", bus.tx_data);
            end else begin
                exp_tx = tx_q.pop_front();
                if (bus.tx_data !== exp_tx) begin
                    bad++;
                    $display("FAIL tx_pop: got tx_data=%h, want %h", bus.tx_data, exp_tx);
                end else begin
                    $display("tx pop: data=%h", bus.tx_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.address = 32'd0;
        bus.wr      = 1'b0;
        rd_issue    = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.address = addr;
        bus.wr      = 1'b1;
        bus.data_in = data;
        rd_issue    = 1'b0;
        cyc();
        bus.wr      = 1'b0;
        bus.address = 32'd0;
        $display("write addr=%h data=%h", addr, data);
    endtask

    task automatic bus_read(input string nm, input logic [31:0] addr,
                            input logic exp_sel, input logic [31:0] exp_data);
        bus.address = addr;
        bus.wr      = 1'b0;
        rd_issue    = 1'b1;
        rd_q.push_back({exp_sel, exp_data});
        rd_name_q.push_back(nm);
        cyc();
        rd_issue    = 1'b0;
        bus.address = 32'd0;
    endtask

    // Write that is also checked as a read: must return the pre-write value.
    task automatic bus_rw(input string nm, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_data);
        bus.address = addr;
        bus.wr      = 1'b1;
        bus.data_in = data;
        rd_issue    = 1'b1;
        rd_q.push_back({1'b1, exp_data});
        rd_name_q.push_back(nm);
        cyc();
        rd_issue    = 1'b0;
        bus.wr      = 1'b0;
        bus.address = 32'd0;
    endtask

    task automatic push_tx(input logic [31:0] data, input logic accepted);
        if (accepted) tx_q.push_back(data);
        bus_write(B + 32'h10, data);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end else begin
            $display("check %s: %h", nm, act);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset       = 1'b1;
        bus.address = 32'd0;
        bus.wr      = 1'b0;
        bus.data_in = 32'd0;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_sel",      {31'd0, bus.sel}, 32'd0);
        chk("rst_irq",      {31'd0, bus.irq}, 32'd0);
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_tx_data",  bus.tx_data, 32'd0);
        bus_read("rst_count",  B + 32'h00, 1'b1, 32'd0);
        bus_read("rst_status", B + 32'h0C, 1'b1, 32'h4);
        bus_read("rst_level",  B + 32'h14, 1'b1, 32'd0);

        // Timer compare and interrupt
        bus_write(B + 32'h04, 32'd5);
        bus_write(B + 32'h00, 32'd0);
        bus_write(B + 32'h08, 32'd3);          // run from here, COUNT=0
        idle(5);                               // COUNT=5 now
        chk("irq_before_match", {31'd0, bus.irq}, 32'd0);
        idle(1);
        chk("irq_after_match", {31'd0, bus.irq}, 32'd1);
        bus_read("status_match", B + 32'h0C, 1'b1, 32'h5);
        bus_read("ctrl_rb",      B + 32'h08, 1'b1, 32'h3);
        bus_write(B + 32'h0C, 32'h1);
        chk("irq_cleared", {31'd0, bus.irq}, 32'd0);
        bus_write(B + 32'h08, 32'h0);          // stops with COUNT=10
        bus_read("count_stopped", B + 32'h00, 1'b1, 32'd10);

        // FIFO fill, overflow, ordered drain
        push_tx(32'hA, 1'b1);
        chk("tx_valid_first", {31'd0, bus.tx_valid}, 32'd1);
        chk("tx_data_first",  bus.tx_data, 32'hA);
        push_tx(32'hB, 1'b1);
        push_tx(32'hC, 1'b1);
        push_tx(32'hD, 1'b1);
        push_tx(32'hE, 1'b0);                  // dropped
        bus_read("level_full",  B + 32'h14, 1'b1, 32'd4);
        bus_read("status_ovf",  B + 32'h0C, 1'b1, 32'hA);
        chk("tx_data_head", bus.tx_data, 32'hA);
        bus.tx_ready = 1'b1;
        idle(4);
        bus.tx_ready = 1'b0;
        chk("tx_valid_drained", {31'd0, bus.tx_valid}, 32'd0);
        bus_write(B + 32'h0C, 32'h8);
        bus_read("status_ovf_clr", B + 32'h0C, 1'b1, 32'h4);

        // Full FIFO with simultaneous push and pop
        push_tx(32'h1, 1'b1);
        push_tx(32'h2, 1'b1);
        push_tx(32'h3, 1'b1);
        push_tx(32'h4, 1'b1);
        bus.tx_ready = 1'b1;
        push_tx(32'h55, 1'b1);
        bus.tx_ready = 1'b0;
        bus_read("level_pushpop",  B + 32'h14, 1'b1, 32'd4);
        bus_read("status_pushpop", B + 32'h0C, 1'b1, 32'h2);
        bus.tx_ready = 1'b1;
        idle(4);
        bus.tx_ready = 1'b0;
        chk("tx_valid_drained2", {31'd0, bus.tx_valid}, 32'd0);

        // COUNT wrap
        bus_write(B + 32'h04, 32'd3);
        bus_write(B + 32'h00, 32'hFFFF_FFFF);
        bus_write(B + 32'h08, 32'h1);
        idle(1);                               // wraps to 0
        bus_read("count_wrap", B + 32'h00, 1'b1, 32'd0);
        bus_write(B + 32'h08, 32'h0);          // stops with COUNT=2
        bus_read("status_no_match", B + 32'h0C, 1'b1, 32'h4);
        bus_read("count_after_wrap", B + 32'h00, 1'b1, 32'd2);

        // Read-during-write, unmapped offsets, out-of-window
        bus_rw("rw_pre_value", B + 32'h04, 32'h77, 32'd3);
        bus_read("cmp_post_write", B + 32'h04, 1'b1, 32'h77);
        bus_read("txdata_reads_0", B + 32'h10, 1'b1, 32'd0);
        bus_read("unmapped_off",   B + 32'h40, 1'b1, 32'd0);
        bus_read("outside_window", 32'h0000_0100, 1'b0, 32'd0);

        // Asynchronous reset mid-transfer
        bus_write(B + 32'h04, 32'd0);
        bus_write(B + 32'h00, 32'd0);
        bus_write(B + 32'h08, 32'h3);
        push_tx(32'h99, 1'b0);                 // discarded by reset
        push_tx(32'h98, 1'b0);
        bus_read("count_live", B + 32'h00, 1'b1, 32'd2);
        bus.address = B;                       // keep data_out/sel busy
        cyc();
        chk("pre_rst_irq",      {31'd0, bus.irq}, 32'd1);
        chk("pre_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("pre_rst_tx_data",  bus.tx_data, 32'h99);
        chk("pre_rst_sel",      {31'd0, bus.sel}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_data_out", bus.data_out, 32'd0);
        chk("async_sel",      {31'd0, bus.sel}, 32'd0);
        chk("async_irq",      {31'd0, bus.irq}, 32'd0);
        chk("async_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("async_tx_data",  bus.tx_data, 32'd0);
        bus.address = 32'd0;
        repeat (2) cyc();
        reset = 1'b0;
        bus_read("post_rst_level",  B + 32'h14, 1'b1, 32'd0);
        bus_read("post_rst_count",  B + 32'h00, 1'b1, 32'd0);
        bus_read("post_rst_status", B + 32'h0C, 1'b1, 32'h4);
        bus_read("post_rst_ctrl",   B + 32'h08, 1'b1, 32'd0);
        idle(3);

        chk("rd_queue_empty", rd_q.size(), 32'd0);
        chk("tx_queue_empty", tx_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
